// File: rtl/alu8_pkg.sv
// alu8_pkg: shared opcode encoding and operand width for the registered ALU
package alu8_pkg;
  localparam int WIDTH = 8;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_ADD = 2'b10, OP_MUL = 2'b11} op_e;
endpackage

// File: rtl/alu8_comb.sv
// alu8_comb: combinational AND/OR/ADD/MUL datapath with full-width result and add carry
module alu8_comb
  import alu8_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic [1:0]     i_op,
  output logic [2*W-1:0] o_result,
  output logic           o_carry
);
  logic [W:0]     w_sum;
  logic [2*W-1:0] w_prod;
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
  always_comb begin
    o_result = (i_op == OP_AND) ? {{W{1'b0}}, i_a & i_b} :
               (i_op == OP_OR)  ? {{W{1'b0}}, i_a | i_b} :
               (i_op == OP_ADD) ? {{(W-1){1'b0}}, w_sum} : w_prod;
    o_carry  = (i_op == OP_ADD) & w_sum[W];
  end
endmodule

// File: rtl/alu8_registered.sv
// alu8_registered: one-cycle registered ALU with valid strobe; result holds while idle
module alu8_registered #(
  parameter int WIDTH = alu8_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op_code,
  output logic [2*WIDTH-1:0] out,
  output logic               c_out,
  output logic               out_valid
);
  logic [2*WIDTH-1:0] w_res;
  logic               w_carry;
  logic [2*WIDTH-1:0] r_out;
  logic               r_c_out;
  logic               r_valid;
  alu8_comb #(.W(WIDTH)) u_comb (
    .i_a      (a),
    .i_b      (b),
    .i_op     (op_code),
    .o_result (w_res),
    .o_carry  (w_carry)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= '0;
      r_c_out <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out   <= w_res;
        r_c_out <= w_carry;
      end
    end
  end
  assign out       = r_out;
  assign c_out     = r_c_out;
  assign out_valid = r_valid;
endmodule

// File: tb/tb_alu8_registered.sv
// tb_alu8_registered: directed checks of {out_valid, c_out, out} against hand-computed values
module tb_alu8_registered;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [1:0]  op_code = '0;
  logic [15:0] out;
  logic        c_out;
  logic        out_valid;
  int total = 0;
  int bad = 0;
  alu8_registered dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op_code   (op_code),
    .out       (out),
    .c_out     (c_out),
    .out_valid (out_valid)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic v, input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] op);
    in_valid = v;
    a        = ia;
    b        = ib;
    op_code  = op;
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [17:0] exp);
    logic [17:0] obs;
    obs = {out_valid, c_out, out};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    #2 chk("reset_init", 18'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 8'h01, 8'h01, 2'b00); cyc(); chk("and_01_01", {2'b10, 16'h0001});
    drive(1, 8'h0F, 8'h0F, 2'b01); cyc(); chk("or_0f_0f",  {2'b10, 16'h000F});
    drive(1, 8'h01, 8'h01, 2'b10); cyc(); chk("add_01_01", {2'b10, 16'h0002});
    drive(1, 8'hFF, 8'h01, 2'b10); cyc(); chk("add_ff_01", {2'b11, 16'h0100});
    drive(1, 8'h0F, 8'h01, 2'b11); cyc(); chk("mul_0f_01", {2'b10, 16'h000F});
    drive(1, 8'hFF, 8'hFF, 2'b11); cyc(); chk("mul_ff_ff", {2'b10, 16'hFE01});
    drive(1, 8'hAA, 8'h0F, 2'b00); cyc(); chk("b2b_and",   {2'b10, 16'h000A});
    drive(1, 8'hA0, 8'h05, 2'b01); cyc(); chk("b2b_or",    {2'b10, 16'h00A5});
    drive(1, 8'h80, 8'h80, 2'b10); cyc(); chk("b2b_add",   {2'b11, 16'h0100});
    drive(1, 8'h10, 8'h10, 2'b11); cyc(); chk("b2b_mul",   {2'b10, 16'h0100});
    drive(0, 8'hFF, 8'hFF, 2'b11); cyc(); chk("hold_1", {2'b00, 16'h0100});
    drive(0, 8'h12, 8'h34, 2'b00); cyc(); chk("hold_2", {2'b00, 16'h0100});
    drive(0, 8'hFF, 8'h01, 2'b10); cyc(); chk("hold_3", {2'b00, 16'h0100});
    drive(1, 8'h7F, 8'h7F, 2'b10); cyc(); chk("add_7f_7f", {2'b10, 16'h00FE});
    drive(0, 8'h00, 8'h00, 2'b01); cyc(); chk("hold_fe",   {2'b00, 16'h00FE});
    #2 rst = 1'b1;
    #1 chk("async_reset", 18'h0);
    drive(1, 8'hFF, 8'hFF, 2'b11); cyc(); chk("reset_wins_edge", 18'h0);
    rst = 1'b0;
    drive(0, 8'hFF, 8'hFF, 2'b11); cyc(); chk("idle_after_reset", 18'h0);
    drive(1, 8'hFF, 8'hFF, 2'b10); cyc(); chk("add_ff_ff", {2'b11, 16'h01FE});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu8_registered.md
Name: alu8_registered

Overview:
- 8-bit, four-function ALU: AND, OR, ADD and MUL, selected by a 2-bit opcode.
- Produces a 16-bit result plus a carry flag.
- Result and flag are registered: one-cycle latency, with a valid strobe.
- Sits as a leaf datapath block; the controller supplies operands and opcode and samples the result one cycle later.

Parameters:
- WIDTH, 8, operand width. Result width is 2*WIDTH. Only 8 needs to be verified.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and opcode are sampled on this cycle.
- a  input  8  operand A, unsigned.
- b  input  8  operand B, unsigned.
- op_code  input  2  function select: 00 AND, 01 OR, 10 ADD, 11 MUL.
- out  output  16  registered result.
- c_out  output  1  registered carry-out; meaningful for ADD only.
- out_valid  output  1  registered; high for one cycle when out/c_out hold a new result.

Behaviour:
- Reset:
  - rst high immediately clears out=16'h0000, c_out=0 and out_valid=0, independent of clk.
  - On rst deassertion, the first capture occurs on the next rising clk edge with in_valid=1.
- Capture:
  - On a rising clk edge with in_valid=1, the combinational result of a, b and op_code is loaded into out/c_out, and out_valid is set to 1.
  - Latency is exactly 1 cycle.
- Hold:
  - With in_valid=0, out and c_out hold their previous values and out_valid goes to 0.
  - Back-to-back in_valid gives one result per cycle; out_valid stays high continuously.
- op 00 AND: out = {8'h00, a & b}; c_out = 0.
- op 01 OR: out = {8'h00, a | b}; c_out = 0.
- op 10 ADD:
  - 9-bit unsigned sum s = a + b, with carry-in = 0.
  - out = {7'b0, s[8], s[7:0]}; c_out = s[8].
  - Wrap-around: 8'hFF + 8'h01 gives out=16'h0100 and c_out=1.
- op 11 MUL:
  - Full unsigned 8x8 product: out = a * b (16 bits, never truncated); c_out = 0.
  - Maximum case: 8'hFF * 8'hFF = 16'hFE01.
- Opcode, a and b matter only on capture edges; changes between edges have no effect on the outputs.
- Reset asserted during a capture edge wins: outputs stay cleared.
- No X propagation: every opcode value is defined, so no default/illegal case exists.

Decomposition:
- Shared package alu8_pkg holds:
  - the opcode enum/localparams (OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_MUL=2'b11);
  - the WIDTH constant.
- One natural sub-module: alu8_comb.
  - A purely combinational datapath with the four function units and a 4:1 result mux.
  - Produces result[15:0] and carry.
- The top level registers those outputs, together with out_valid.
- The adder and multiplier may be behavioural, or structural (ripple-carry full adders; shift-add array multiplier). Either is acceptable provided they are bit-exact.

Test Plan:
- Reset: assert rst mid-operation with out=16'h00FE held -> out=0, c_out=0, out_valid=0 immediately, without waiting for a clock edge.
- AND/OR:
  - a=8'h01, b=8'h01, op=00 -> next cycle out=16'h0001, c_out=0, out_valid=1.
  - a=8'h0F, b=8'h0F, op=01 -> out=16'h000F, c_out=0.
- ADD:
  - a=8'h01, b=8'h01, op=10 -> out=16'h0002, c_out=0.
  - a=8'hFF, b=8'h01, op=10 -> out=16'h0100, c_out=1.
- MUL:
  - a=8'h0F, b=8'h01, op=11 -> out=16'h000F.
  - a=8'hFF, b=8'hFF, op=11 -> out=16'hFE01, c_out=0.
- Hold/pipelining:
  - Four back-to-back valid inputs -> four results on consecutive cycles, out_valid high for all four.
  - Then in_valid=0 with a, b and op_code toggling -> out unchanged, out_valid=0.
